// File: rtl/ir_cmd_encoder_if.sv
// Bus between the IR frame source, the encoder and the UART transmitter.
// Handshake: a byte moves on every clock edge where tx_valid and tx_ready are
// both high; while tx_valid=1 and tx_ready=0 the encoder keeps tx_byte stable
// and holds tx_valid high.
interface ir_cmd_encoder_if;
    logic        frame_ready;
    logic [31:0] frame_data;
    logic [1:0]  mode;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic        key_active;
    logic [2:0]  cur_dir;
    logic [7:0]  err_count;
    logic [1:0]  fsm_state;

    // Encoder side: consumes frames and the UART ready, produces bytes.
    modport master (
        input  frame_ready, frame_data, mode, tx_ready,
        output tx_byte, tx_valid, key_active, cur_dir, err_count, fsm_state
    );

    // Environment side: produces frames and ready, observes bytes.
    modport slave (
        output frame_ready, frame_data, mode, tx_ready,
        input  tx_byte, tx_valid, key_active, cur_dir, err_count, fsm_state
    );
endinterface

// File: rtl/ir_cmd_encoder.sv
// Turns decoded NEC frames into one command byte per key press plus a stop
// byte once the key has been released for HOLD_CYCLES+1 clocks.
module ir_cmd_encoder #(
    parameter int         HOLD_CYCLES = 7_500_000,
    parameter logic [7:0] STOP_BYTE   = 8'h00
) (
    input  logic          clk,
    input  logic          rst,
    ir_cmd_encoder_if.master bus
);
    localparam int TW = $clog2(HOLD_CYCLES + 1);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES);

    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, HOLD = 2'd2, STOP = 2'd3} state_t;

    // frame intake stage
    logic       frame_ready_q;
    logic       frm_vld;
    logic [2:0] frm_dir;
    logic [7:0] err_q;
    logic [7:0] cmd;
    logic       check_ok;
    logic       map_ok;
    logic [2:0] map_dir;
    logic       frame_edge;

    // FSM and datapath registers with their next values
    state_t        state_q, state_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          key_active_q, key_active_d;
    logic [2:0]    cur_dir_q, cur_dir_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pend_full_q, pend_full_d;
    logic [2:0]    pend_dir_q, pend_dir_d;
    logic          do_load;
    logic [2:0]    load_dir;
    logic          eff_full;
    logic [2:0]    eff_dir;

    assign frame_edge = bus.frame_ready & ~frame_ready_q;

    // Check-byte validation and key-to-direction map.
    always_comb begin
        cmd      = bus.frame_data[23:16];
        check_ok = (bus.frame_data[31:24] == ~cmd);
        map_ok   = 1'b1;
        map_dir  = 3'd0;
        case (cmd)
            8'h00:   map_dir = 3'd0;
            8'h02:   map_dir = 3'd1;
            8'h04:   map_dir = 3'd3;
            8'h05:   map_dir = 3'd4;
            8'h06:   map_dir = 3'd5;
            8'h08:   map_dir = 3'd7;
            default: map_ok  = 1'b0;
        endcase
    end

    // Register the frame edge and its decode; count rejected frames, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_ready_q <= 1'b0;
            frm_vld       <= 1'b0;
            frm_dir       <= 3'd0;
            err_q         <= 8'h00;
        end else begin
            frame_ready_q <= bus.frame_ready;
            frm_vld       <= frame_edge & check_ok & map_ok;
            frm_dir       <= map_dir;
            if (frame_edge && !(check_ok && map_ok) && err_q != 8'hFF)
                err_q <= err_q + 8'd1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            tx_byte_q    <= 8'h00;
            key_active_q <= 1'b0;
            cur_dir_q    <= 3'd0;
            timer_q      <= '0;
            pend_full_q  <= 1'b0;
            pend_dir_q   <= 3'd0;
        end else begin
            state_q      <= state_d;
            tx_byte_q    <= tx_byte_d;
            key_active_q <= key_active_d;
            cur_dir_q    <= cur_dir_d;
            timer_q      <= timer_d;
            pend_full_q  <= pend_full_d;
            pend_dir_q   <= pend_dir_d;
        end
    end

    // Next state and datapath; a frame arriving in the handshake cycle counts
    // as the newest pending frame.
    always_comb begin
        state_d      = state_q;
        tx_byte_d    = tx_byte_q;
        key_active_d = key_active_q;
        cur_dir_d    = cur_dir_q;
        timer_d      = timer_q;
        pend_full_d  = pend_full_q;
        pend_dir_d   = pend_dir_q;
        do_load      = 1'b0;
        load_dir     = frm_dir;
        eff_full     = frm_vld | pend_full_q;
        eff_dir      = frm_vld ? frm_dir : pend_dir_q;

        case (state_q)
            IDLE: begin
                if (frm_vld) begin
                    do_load  = 1'b1;
                    load_dir = frm_dir;
                end
            end
            SEND: begin
                if (bus.tx_ready) begin
                    pend_full_d = 1'b0;
                    if (eff_full && eff_dir != cur_dir_q) begin
                        do_load  = 1'b1;
                        load_dir = eff_dir;
                    end else begin
                        state_d = HOLD;
                        timer_d = HOLD_LOAD;
                    end
                end else if (frm_vld) begin
                    pend_full_d = 1'b1;
                    pend_dir_d  = frm_dir;
                end
            end
            HOLD: begin
                if (frm_vld) begin
                    if (frm_dir == cur_dir_q) begin
                        timer_d = HOLD_LOAD;
                    end else begin
                        do_load  = 1'b1;
                        load_dir = frm_dir;
                    end
                end else if (timer_q == '0) begin
                    tx_byte_d    = STOP_BYTE;
                    key_active_d = 1'b0;
                    state_d      = STOP;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            STOP: begin
                if (bus.tx_ready) begin
                    pend_full_d = 1'b0;
                    if (eff_full) begin
                        do_load  = 1'b1;
                        load_dir = eff_dir;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (frm_vld) begin
                    pend_full_d = 1'b1;
                    pend_dir_d  = frm_dir;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_load) begin
            tx_byte_d    = {bus.mode, load_dir, 3'b000};
            cur_dir_d    = load_dir;
            key_active_d = 1'b1;
            state_d      = SEND;
        end
    end

    // Outputs: a byte is offered in SEND and STOP.
    always_comb begin
        bus.tx_valid   = (state_q == SEND) || (state_q == STOP);
        bus.tx_byte    = tx_byte_q;
        bus.key_active = key_active_q;
        bus.cur_dir    = cur_dir_q;
        bus.err_count  = err_q;
        bus.fsm_state  = state_q;
    end
endmodule

// File: tb/tb_ir_cmd_encoder.sv
// Directed bench for ir_cmd_encoder with HOLD_CYCLES=20.
module tb_ir_cmd_encoder;
    logic clk;
    logic rst;
    ir_cmd_encoder_if bus();

    ir_cmd_encoder #(.HOLD_CYCLES(20), .STOP_BYTE(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    int hs_cnt    = 0;
    logic [7:0] exp_q[$];
    logic       stall_q   = 1'b0;
    logic [7:0] held_byte = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: pop on every handshake, and hold bytes stable while stalled
    task automatic monitor();
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q && bus.tx_valid)
                check("hold_stable", {24'h0, bus.tx_byte}, {24'h0, held_byte});
            if (bus.tx_valid && bus.tx_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    fail_cnt++;
                    $error("FAIL unexpected_byte: observed %0h expected none", bus.tx_byte);
                end else begin
                    check("tx_byte", {24'h0, bus.tx_byte}, {24'h0, exp_q.pop_front()});
                end
            end
            stall_q   = bus.tx_valid && !bus.tx_ready;
            held_byte = bus.tx_byte;
        end
    endtask

    // one cycle: sample at the falling edge, return 1 time unit after the rising edge
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            monitor();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] data);
        bus.frame_ready = 1'b1;
        bus.frame_data  = data;
        tick(1);
        bus.frame_ready = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int bound);
        int c = 0;
        while (exp_q.size() != 0 && c < bound) begin
            tick(1);
            c++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int hs_base;
        rst             = 1'b1;
        bus.frame_ready = 1'b0;
        bus.frame_data  = 32'h0;
        bus.mode        = 2'b00;
        bus.tx_ready    = 1'b0;
        tick(3);

        // T1: reset values, then first key press
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_tx_byte", bus.tx_byte, 0);
        check("rst_key_active", bus.key_active, 0);
        check("rst_cur_dir", bus.cur_dir, 0);
        check("rst_err_count", bus.err_count, 0);
        check("rst_state", bus.fsm_state, 0);
        rst          = 1'b0;
        bus.mode     = 2'b10;
        bus.tx_ready = 1'b1;
        exp_q.push_back(8'h88);
        send(32'hFD02_1234);
        check("t1_valid_early", bus.tx_valid, 0);
        tick(1);
        check("t1_valid_rise", bus.tx_valid, 1);
        check("t1_key_active", bus.key_active, 1);
        check("t1_cur_dir", bus.cur_dir, 1);
        tick(1);
        check("t1_valid_fall", bus.tx_valid, 0);

        // T2: repeats every 10 cycles keep the key held, then release
        for (int i = 0; i < 5; i++) begin
            tick(9);
            send(32'hFD02_0000);
        end
        exp_q.push_back(8'h00);
        c = 0;
        while (!bus.tx_valid && c < 60) begin
            tick(1);
            c++;
        end
        // frame decoded at edge 0, timer reload at edge 1, stop 21 cycles later
        check("t2_stop_delay", c, 22);
        tick(2);
        check("t2_key_released", bus.key_active, 0);
        check("t2_drained", exp_q.size(), 0);

        // T3: direction change during HOLD, no stop in between
        bus.mode = 2'b00;
        exp_q.push_back(8'h18);
        send(32'hFB04_0000);
        tick(6);
        exp_q.push_back(8'h28);
        send(32'hF906_0000);
        tick(2);
        check("t3_cur_dir", bus.cur_dir, 5);
        check("t3_key_active", bus.key_active, 1);
        exp_q.push_back(8'h00);
        wait_drain("t3_drain", 80);
        tick(2);

        // T4: stalled UART; newer pending frame overwrites older
        bus.tx_ready = 1'b0;
        exp_q.push_back(8'h18);
        send(32'hFB04_0000);
        tick(3);
        check("t4_stall_valid", bus.tx_valid, 1);
        check("t4_stall_byte", bus.tx_byte, 8'h18);
        send(32'hFA05_0000);
        tick(3);
        send(32'hF906_0000);
        exp_q.push_back(8'h28);
        tick(40);
        check("t4_stall_end_byte", bus.tx_byte, 8'h18);
        bus.tx_ready = 1'b1;
        exp_q.push_back(8'h00);
        wait_drain("t4_drain", 80);
        tick(2);
        check("t4_key_released", bus.key_active, 0);

        // T5: rejected frames only count errors
        send(32'hFE02_0000);
        tick(1);
        send(32'hF70A_0000);
        tick(1);
        check("t5_err_two", bus.err_count, 2);
        for (int i = 0; i < 300; i++) begin
            send(32'hFE02_0000);
            tick(1);
            if (i == 252) check("t5_err_reach_ff", bus.err_count, 8'hFF);
        end
        check("t5_err_saturated", bus.err_count, 8'hFF);
        check("t5_no_valid", bus.tx_valid, 0);
        check("t5_no_key", bus.key_active, 0);

        // T6: reset mid-SEND, then a level held high counts once
        bus.tx_ready = 1'b0;
        send(32'hFB04_0000);
        tick(2);
        check("t6_in_send", bus.tx_valid, 1);
        rst = 1'b1;
        tick(1);
        check("t6_rst_valid", bus.tx_valid, 0);
        check("t6_rst_key", bus.key_active, 0);
        check("t6_rst_err", bus.err_count, 0);
        check("t6_rst_state", bus.fsm_state, 0);
        rst          = 1'b0;
        bus.tx_ready = 1'b1;
        hs_base      = hs_cnt;
        exp_q.push_back(8'h18);
        exp_q.push_back(8'h00);
        bus.frame_ready = 1'b1;
        bus.frame_data  = 32'hFB04_0000;
        tick(40);
        bus.frame_ready = 1'b0;
        wait_drain("t6_drain", 40);
        tick(10);
        check("t6_handshakes", hs_cnt - hs_base, 2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
